fetch_prefetch_queue: RTL and testbench

//  Fetch-side front end for the 5-stage MIPS core. Drives InstructionMemory addresses and buffers returned words.

---
 rtl/fetch_prefetch_queue_if.sv | 33 +++
 rtl/fetch_prefetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-unit bundle: redirect/control inputs, instruction-memory port and decode handshake.
interface fetch_prefetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic [ADDR_W-1:0] dec_pc_plus4;
    logic [CNT_W-1:0]  q_count;

    // Fetch unit side
    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_rdata, dec_ready,
        output imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, q_count
    );

    // Core / memory side
    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_rdata, dec_ready,
        input  imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, q_count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: issues word reads, queues returned instructions for decode, flushes on redirect.
// Optional FETCH_PERF_CNT_EN adds saturating flush/stall counters.
module fetch_prefetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    fetch_prefetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]        state, stateNext;
    logic [ADDR_W-1:0] fetchPc, inflightPc;
    logic              inflight;
    logic [DATA_W-1:0] qInstr [DEPTH];
    logic [ADDR_W-1:0] qPc    [DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] holdInstr;
    logic [ADDR_W-1:0] holdPc, holdPcPlus4;

    logic              creditOk, reqValid, headValid, push, pop, flush;
    logic [DATA_W-1:0] headInstr;
    logic [ADDR_W-1:0] headPc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= stateNext;
    end

    // Next state, request decision and queue handshake
    always_comb begin
        stateNext = state;
        creditOk  = 1'b0;
        reqValid  = 1'b0;
        headValid = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        headInstr = qInstr[rdPtr];
        headPc    = qPc[rdPtr];

        flush     = bus.redirect_valid;
        creditOk  = ((CNT_W+1)'(count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH);
        reqValid  = (state == RUN) && creditOk && !flush;
        headValid = (count != '0);
        pop       = headValid && bus.dec_ready;
        push      = inflight && !flush;

        case (state)
            BOOT:    stateNext = bus.fetch_en ? RUN : PAUSE;
            RUN:     if (!bus.fetch_en) stateNext = PAUSE;
            PAUSE:   if (bus.fetch_en) stateNext = RUN;
            default: stateNext = BOOT;
        endcase
    end

    // Fetch PC, in-flight tracking, queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
        end else begin
            inflight <= reqValid;
            if (reqValid) inflightPc <= fetchPc;
            if (flush) begin
                fetchPc <= bus.redirect_pc & ~ADDR_W'(3);
                wrPtr   <= '0;
                rdPtr   <= '0;
                count   <= '0;
            end else begin
                if (reqValid) fetchPc <= fetchPc + ADDR_W'(4);
                if (push)     wrPtr   <= wrPtr + PTR_W'(1);
                if (pop)      rdPtr   <= rdPtr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qInstr[wrPtr] <= bus.imem_rdata;
            qPc[wrPtr]    <= inflightPc;
        end
    end

    // Last presented head, shown while the queue is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdInstr   <= '0;
            holdPc      <= '0;
            holdPcPlus4 <= '0;
        end else if (headValid) begin
            holdInstr   <= headInstr;
            holdPc      <= headPc;
            holdPcPlus4 <= headPc + ADDR_W'(4);
        end
    end

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_addr      = reqValid ? fetchPc : '0;
    assign bus.dec_valid      = headValid;
    assign bus.dec_instr      = headValid ? headInstr : holdInstr;
    assign bus.dec_pc         = headValid ? headPc : holdPc;
    assign bus.dec_pc_plus4   = headValid ? headPc + ADDR_W'(4) : holdPcPlus4;
    assign bus.q_count        = count;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (headValid && !bus.dec_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed vector table, randomized run against
// a queue-based reference model, and a PC-wrap check on a second instance.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFlush, perfStall, perfFlush2, perfStall2;
`endif

    fetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h0))
    dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_flush_cnt(perfFlush),
        .perf_stall_cnt(perfStall)
`endif
    );

    fetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'hFFFF_FFF8))
    dutWrap (
        .clk(clk),
        .rst(rst2),
        .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_flush_cnt(perfFlush2),
        .perf_stall_cnt(perfStall2)
`endif
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Reference model: a plain queue of PCs plus one optional outstanding read
    typedef enum {M_BOOT, M_RUN, M_PAUSE} mode_e;
    mode_e       mMode;
    logic [31:0] mQ[$];
    bit          mInfl;
    logic [31:0] mInflPc, mFetchPc, mLastPc, mLastInstr, mLastPlus4;
    logic [31:0] mFlush, mStall;
    bit          eReq, eValid;

    bit          curRn, curFe, curRv, curDr;
    logic [31:0] curRpc;
    bit          memPend = 1'b0;
    logic [31:0] memAddr = '0;

    task automatic mReset();
        mMode = M_BOOT; mQ.delete(); mInfl = 0; mInflPc = '0; mFetchPc = 32'h0;
        mLastPc = '0; mLastInstr = '0; mLastPlus4 = '0; mFlush = '0; mStall = '0;
    endtask

    task automatic applyInputs(input bit rn, input bit fe, input bit rv, input logic [31:0] rpc,
                               input bit dr);
        curRn = rn; curFe = fe; curRv = rv; curRpc = rpc; curDr = dr;
        rst = rn;
        bus.fetch_en = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.dec_ready = dr;
        bus.imem_rdata = memPend ? instrOf(memAddr) : $urandom();
    endtask

    task automatic checkModel();
        logic [31:0] ePc, eInstr, ePlus4;
        if (!curRn) mReset();
        eValid = (mQ.size() != 0);
        eReq   = (mMode == M_RUN) && ((mQ.size() + int'(mInfl)) < int'(DEPTH)) && !curRv;
        ePc    = eValid ? mQ[0] : mLastPc;
        eInstr = eValid ? instrOf(mQ[0]) : mLastInstr;
        ePlus4 = eValid ? mQ[0] + 32'd4 : mLastPlus4;
        check("model req_valid", 32'(bus.imem_req_valid), 32'(eReq));
        check("model imem_addr", bus.imem_addr, eReq ? mFetchPc : 32'h0);
        check("model dec_valid", 32'(bus.dec_valid), 32'(eValid));
        check("model dec_pc", bus.dec_pc, ePc);
        check("model dec_instr", bus.dec_instr, eInstr);
        check("model dec_pc_plus4", bus.dec_pc_plus4, ePlus4);
        check("model q_count", 32'(bus.q_count), 32'(mQ.size()));
`ifdef FETCH_PERF_CNT_EN
        check("model perf_flush", perfFlush, mFlush);
        check("model perf_stall", perfStall, mStall);
`endif
        memPend = bus.imem_req_valid;
        memAddr = bus.imem_addr;
    endtask

    task automatic advance();
        if (!curRn) begin
            mReset();
            return;
        end
        if (eValid) begin
            mLastPc = mQ[0]; mLastInstr = instrOf(mQ[0]); mLastPlus4 = mQ[0] + 32'd4;
        end
        if (curRv && mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 32'd1;
        if (eValid && !curDr && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
        if (eValid && curDr) void'(mQ.pop_front());
        if (curRv) begin
            mQ.delete();
            mInfl = 0;
            mFetchPc = curRpc & 32'hFFFF_FFFC;
        end else begin
            if (mInfl) mQ.push_back(mInflPc);
            mInfl = eReq;
            if (eReq) begin
                mInflPc = mFetchPc;
                mFetchPc = mFetchPc + 32'd4;
            end
        end
        mMode = curFe ? M_RUN : M_PAUSE;
    endtask

    typedef struct {
        bit rn; bit fe; bit rv; logic [31:0] rpc; bit dr;
        bit req; logic [31:0] addr; bit vld; logic [31:0] pc; int cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit fe, bit rv, logic [31:0] rpc, bit dr,
                                bit req, logic [31:0] addr, bit vld, logic [31:0] pc, int cnt);
        vec_t v;
        v.rn = rn; v.fe = fe; v.rv = rv; v.rpc = rpc; v.dr = dr;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int drPct;
        int seen;
        bit pend2;
        logic [31:0] addr2, ePc2;

        rst = 1'b0; rst2 = 1'b0;
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.dec_ready = 1'b0; bus.imem_rdata = '0;
        bus2.fetch_en = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
        bus2.dec_ready = 1'b1; bus2.imem_rdata = '0;
        mReset();

        // rn fe rv rpc dr | req addr vld pc cnt
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,1, 0,32'h00,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h00,0,32'h00,0));   // boot cycle
        tbl.push_back(mk(1,1,0,0,1, 1,32'h00,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h04,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h08,1,32'h00,1));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h0C,1,32'h04,1));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h10,1,32'h08,1));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h14,1,32'h0C,1));
        tbl.push_back(mk(1,1,0,0,0, 1,32'h18,1,32'h10,1));   // decode stalls
        tbl.push_back(mk(1,1,0,0,0, 1,32'h1C,1,32'h10,2));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h00,1,32'h10,3));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h00,1,32'h10,4));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h00,1,32'h10,4));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h00,1,32'h10,4));   // pop while full, no credit yet
        tbl.push_back(mk(1,1,0,0,1, 1,32'h20,1,32'h14,3));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h24,1,32'h18,2));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h28,1,32'h1C,2));
        tbl.push_back(mk(1,1,0,0,0, 1,32'h2C,1,32'h20,2));
        tbl.push_back(mk(1,1,1,32'h43,0, 0,32'h00,1,32'h20,3)); // redirect, 3 queued + 1 in flight
        tbl.push_back(mk(1,1,0,0,1, 1,32'h40,0,32'h20,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h44,0,32'h20,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h48,1,32'h40,1));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h4C,1,32'h44,1));
        tbl.push_back(mk(1,1,0,0,0, 1,32'h50,1,32'h48,1));
        tbl.push_back(mk(1,1,0,0,0, 1,32'h54,1,32'h48,2));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h00,1,32'h48,3));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h00,1,32'h48,4));
        tbl.push_back(mk(0,1,0,0,0, 0,32'h00,0,32'h00,0));   // reset with queue full
        tbl.push_back(mk(1,1,0,0,1, 0,32'h00,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h00,0,32'h00,0));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            applyInputs(tbl[i].rn, tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].dr);
            @(negedge clk);
            check($sformatf("row%0d req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].req));
            check($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].addr);
            check($sformatf("row%0d dec_valid", i), 32'(bus.dec_valid), 32'(tbl[i].vld));
            check($sformatf("row%0d dec_pc", i), bus.dec_pc, tbl[i].pc);
            check($sformatf("row%0d q_count", i), 32'(bus.q_count), 32'(tbl[i].cnt));
            checkModel();
            @(posedge clk); advance(); #1;
        end

        // Randomized traffic with varying decode back-pressure
        drPct = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) drPct = $urandom_range(10, 100);
            applyInputs($urandom_range(0, 249) != 0, $urandom_range(0, 9) != 0,
                         $urandom_range(0, 11) == 0, $urandom(),
                         $urandom_range(0, 99) < drPct);
            @(negedge clk);
            checkModel();
            @(posedge clk); advance(); #1;
        end

        // PC wrap across the top of the address space
        @(negedge clk);
        check("wrap reset dec_valid", 32'(bus2.dec_valid), 32'h0);
        check("wrap reset q_count", 32'(bus2.q_count), 32'h0);
        check("wrap reset dec_pc", bus2.dec_pc, 32'h0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        pend2 = 1'b0; addr2 = '0; seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            bus2.imem_rdata = pend2 ? instrOf(addr2) : $urandom();
            @(negedge clk);
            if (bus2.dec_valid) begin
                ePc2 = 32'hFFFF_FFF8 + 32'(seen * 4);
                check($sformatf("wrap dec_pc #%0d", seen), bus2.dec_pc, ePc2);
                check($sformatf("wrap dec_pc_plus4 #%0d", seen), bus2.dec_pc_plus4, ePc2 + 32'd4);
                check($sformatf("wrap dec_instr #%0d", seen), bus2.dec_instr, instrOf(ePc2));
                seen++;
            end
            pend2 = bus2.imem_req_valid;
            addr2 = bus2.imem_addr;
            @(posedge clk); #1;
        end
        check("wrap entries seen", 32'(seen), 32'd3);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
